// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared edge-select constants and conditioner state encoding
package timer_pkg;

    localparam logic [1:0] EDGE_NONE = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } cond_state_t;

endpackage

// File: rtl/extin_sync.sv
// rtl/extin_sync.sv - multi-stage synchroniser for the raw external pin
module extin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ext_raw,
    output logic sync_q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the raw pin through the flop chain; the last stage is the only safe consumer view.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], ext_raw};
        end
    end

    assign sync_q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/extin_cond.sv
// rtl/extin_cond.sv - external input conditioner (sync, glitch filter, edge pulse); option EXTIN_EDGE_COUNT_EN
module extin_cond
    import timer_pkg::*;
#(
    parameter int FILT_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_raw,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [1:0]        edge_sel,
    output logic              ext_out,
    output logic              edge_pulse
`ifdef EXTIN_EDGE_COUNT_EN
    ,
    input  logic              cnt_clr,
    output logic [15:0]       edge_count
`endif
);

    logic              sync_q;
    cond_state_t       state, state_nxt;
    logic [FILT_W-1:0] qcnt, qcnt_nxt;
    logic              toggle;
    logic              pulse_nxt;
    logic              sel_rise, sel_fall;

    extin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .ext_raw(ext_raw),
        .sync_q (sync_q)
    );

    assign sel_rise = (edge_sel == EDGE_RISE) || (edge_sel == EDGE_BOTH);
    assign sel_fall = (edge_sel == EDGE_FALL) || (edge_sel == EDGE_BOTH);

    // Stability filter: a differing sync_q must persist for filt_len cycles before ext_out follows it.
    always_comb begin
        state_nxt = state;
        qcnt_nxt  = qcnt;
        toggle    = 1'b0;
        case (state)
            STABLE: begin
                if (sync_q != ext_out) begin
                    if (filt_len == '0) begin
                        toggle = 1'b1;
                    end else begin
                        state_nxt = QUALIFY;
                        qcnt_nxt  = FILT_W'(1);
                    end
                end
            end
            QUALIFY: begin
                if (sync_q == ext_out) begin
                    state_nxt = STABLE;
                    qcnt_nxt  = '0;
                end else if (qcnt >= filt_len) begin
                    toggle    = 1'b1;
                    state_nxt = STABLE;
                    qcnt_nxt  = '0;
                end else begin
                    qcnt_nxt  = qcnt + FILT_W'(1);
                end
            end
            default: begin
                state_nxt = STABLE;
                qcnt_nxt  = '0;
            end
        endcase
        pulse_nxt = toggle & ((~ext_out & sel_rise) | (ext_out & sel_fall));
    end

    // State, qualify counter, filtered level and the registered edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= STABLE;
            qcnt       <= '0;
            ext_out    <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            qcnt       <= qcnt_nxt;
            ext_out    <= ext_out ^ toggle;
            edge_pulse <= pulse_nxt;
        end
    end

`ifdef EXTIN_EDGE_COUNT_EN
    // Saturating count of emitted pulses; a clear that coincides with a pulse keeps that pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_count <= '0;
        end else if (cnt_clr) begin
            edge_count <= pulse_nxt ? 16'd1 : 16'd0;
        end else if (pulse_nxt && (edge_count != 16'hFFFF)) begin
            edge_count <= edge_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_extin_cond.sv
// tb/tb_extin_cond.sv - directed self-checking bench for extin_cond
module tb_extin_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic       ext_raw;
    logic [7:0] filt_len;
    logic [1:0] edge_sel;
    logic       ext_out;
    logic       edge_pulse;
`ifdef EXTIN_EDGE_COUNT_EN
    logic       cnt_clr;
    logic [15:0] edge_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    extin_cond #(
        .FILT_W     (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ext_raw   (ext_raw),
        .filt_len  (filt_len),
        .edge_sel  (edge_sel),
        .ext_out   (ext_out),
        .edge_pulse(edge_pulse)
`ifdef EXTIN_EDGE_COUNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .edge_count(edge_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b0;
        ext_raw  = 1'b0;
        filt_len = 8'd0;
        edge_sel = 2'b01;
`ifdef EXTIN_EDGE_COUNT_EN
        cnt_clr  = 1'b0;
`endif
        tick(3);
        check("reset_ext_out", 32'(ext_out), 0);
        check("reset_pulse", 32'(edge_pulse), 0);
`ifdef EXTIN_EDGE_COUNT_EN
        check("reset_count", 32'(edge_count), 0);
`endif
        rst = 1'b1;
        tick(3);

        // 1: bypass, rising selected, toggle on the third edge
        ext_raw = 1'b1;
        tick(1);
        check("t1_e1_out", 32'(ext_out), 0);
        tick(1);
        check("t1_e2_out", 32'(ext_out), 0);
        tick(1);
        check("t1_e3_out", 32'(ext_out), 1);
        check("t1_e3_pulse", 32'(edge_pulse), 1);
        tick(1);
        check("t1_e4_pulse", 32'(edge_pulse), 0);
        check("t1_e4_out", 32'(ext_out), 1);
        ext_raw = 1'b0;
        tick(3);
        check("t1_fall_out", 32'(ext_out), 0);
        check("t1_fall_nopulse", 32'(edge_pulse), 0);
        tick(2);

        // 2: filt_len=4, 3-cycle glitch rejected, then a held high accepted at edge 7
        filt_len = 8'd4;
        ext_raw  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("t2_glitch_out", 32'(ext_out), 0);
        end
        ext_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("t2_glitch_out", 32'(ext_out), 0);
            check("t2_glitch_pulse", 32'(edge_pulse), 0);
        end
        ext_raw = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("t2_hold_out", 32'(ext_out), 0);
        end
        tick(1);
        check("t2_e7_out", 32'(ext_out), 1);
        check("t2_e7_pulse", 32'(edge_pulse), 1);
        tick(1);
        check("t2_e8_pulse", 32'(edge_pulse), 0);
        ext_raw = 1'b0;
        tick(7);
        check("t2_fall_out", 32'(ext_out), 0);
        tick(2);

        // 3: falling-only selection, then no selection
        filt_len = 8'd0;
        edge_sel = 2'b10;
        ext_raw  = 1'b1;
        tick(3);
        check("t3_rise_out", 32'(ext_out), 1);
        check("t3_rise_nopulse", 32'(edge_pulse), 0);
        ext_raw = 1'b0;
        tick(3);
        check("t3_fall_out", 32'(ext_out), 0);
        check("t3_fall_pulse", 32'(edge_pulse), 1);
        tick(1);
        check("t3_fall_width", 32'(edge_pulse), 0);
        edge_sel = 2'b00;
        for (int i = 0; i < 20; i++) begin
            ext_raw = ((i / 4) % 2) == 0;
            tick(1);
            check("t3_none_pulse", 32'(edge_pulse), 0);
        end
        ext_raw = 1'b0;
        tick(4);

        // 4: shrink filt_len while qcnt=5 -> toggle on the very next edge
        edge_sel = 2'b01;
        filt_len = 8'd8;
        ext_raw  = 1'b1;
        tick(7);
        check("t4_q5_out", 32'(ext_out), 0);
        filt_len = 8'd2;
        tick(1);
        check("t4_out", 32'(ext_out), 1);
        check("t4_pulse", 32'(edge_pulse), 1);
        filt_len = 8'd0;
        ext_raw  = 1'b0;
        tick(4);
        check("t4_back_out", 32'(ext_out), 0);

        // 5: reset mid-QUALIFY, then release with ext_raw high
        filt_len = 8'd4;
        ext_raw  = 1'b1;
        tick(5);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_out", 32'(ext_out), 0);
        check("t5_rst_pulse", 32'(edge_pulse), 0);
        tick(2);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            check("t5_rel_out", 32'(ext_out), 0);
            check("t5_rel_pulse", 32'(edge_pulse), 0);
        end
        tick(1);
        check("t5_e7_out", 32'(ext_out), 1);
        check("t5_e7_pulse", 32'(edge_pulse), 1);
        tick(2);
        #2 rst = 1'b0;
        #1;
        check("t5_async_out", 32'(ext_out), 0);
        ext_raw = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);

`ifdef EXTIN_EDGE_COUNT_EN
        // 6: saturation and clear interaction
        filt_len = 8'd0;
        edge_sel = 2'b11;
        cnt_clr  = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("t6_clr", 32'(edge_count), 0);
        ext_raw = 1'b1;
        tick(4);
        check("t6_one", 32'(edge_count), 1);
        for (int i = 0; i < 70000; i++) begin
            ext_raw = ~ext_raw;
            tick(1);
        end
        check("t6_sat", 32'(edge_count), 32'hFFFF);
        ext_raw = ~ext_raw;
        cnt_clr = 1'b1;
        tick(1);
        check("t6_coinc", 32'(edge_count), 1);
        check("t6_coinc_pulse", 32'(edge_pulse), 1);
        cnt_clr = 1'b0;
        tick(4);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("t6_clr_alone", 32'(edge_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
